// File: rtl/qed_dup_encoder.sv
// QED duplicate encoder: passes original RV32I instructions, then replays register-shifted duplicates.
// Optional QED_MEM_OFFSET_EN also offsets LW/SW immediates by 12'h400 in duplicates.
module qed_dup_encoder #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ena,
    input  logic                       drain,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic                       out_is_dup,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       illegal
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {ORIG, DUP} state_t;

    state_t            state, state_nxt;
    logic [31:0]       mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              full, push, pop;

    function automatic logic is_r(input logic [31:0] x);
        return x[6:0] == 7'b0110011;
    endfunction

    function automatic logic is_i(input logic [31:0] x);
        return x[6:0] == 7'b0010011;
    endfunction

    function automatic logic is_lw(input logic [31:0] x);
        return (x[6:0] == 7'b0000011) && (x[14:12] == 3'b010);
    endfunction

    function automatic logic is_sw(input logic [31:0] x);
        return (x[6:0] == 7'b0100011) && (x[14:12] == 3'b010);
    endfunction

    function automatic logic supported(input logic [31:0] x);
        return is_r(x) || is_i(x) || is_lw(x) || is_sw(x);
    endfunction

    // Bit 4 of a used register field marks the upper (x16..x31) half.
    function automatic logic uses_hi(input logic [31:0] x);
        logic hi;
        hi = 1'b0;
        if (is_r(x))
            hi = x[11] | x[19] | x[24];
        else if (is_i(x) || is_lw(x))
            hi = x[11] | x[19];
        else if (is_sw(x))
            hi = x[19] | x[24];
        return hi;
    endfunction

    function automatic logic [4:0] bump(input logic [4:0] f);
        return (f == 5'd0) ? f : (f | 5'd16);
    endfunction

    function automatic logic [31:0] encode(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        if (is_r(x)) begin
            y[11:7]  = bump(x[11:7]);
            y[19:15] = bump(x[19:15]);
            y[24:20] = bump(x[24:20]);
        end else if (is_i(x) || is_lw(x)) begin
            y[11:7]  = bump(x[11:7]);
            y[19:15] = bump(x[19:15]);
        end else if (is_sw(x)) begin
            y[19:15] = bump(x[19:15]);
            y[24:20] = bump(x[24:20]);
        end
`ifdef QED_MEM_OFFSET_EN
        if (is_lw(x) || is_sw(x))
            y[30] = 1'b1;
`else
`endif
        return y;
    endfunction

    assign full = (fifo_count == CW'(DEPTH));
    assign push = (state == ORIG) && ena && in_valid && in_ready
                  && supported(in_instr);
    assign pop  = (state == DUP) && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ORIG;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            illegal    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push) begin
                wr_ptr     <= wr_ptr + AW'(1);
                fifo_count <= fifo_count + CW'(1);
                if (uses_hi(in_instr))
                    illegal <= 1'b1;
            end else if (pop) begin
                rd_ptr     <= rd_ptr + AW'(1);
                fifo_count <= fifo_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_instr;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ORIG: begin
                if (push && fifo_count == CW'(DEPTH - 1))
                    state_nxt = DUP;
                else if (!push && drain && fifo_count != '0)
                    state_nxt = DUP;
            end
            DUP: begin
                if (pop && fifo_count == CW'(1))
                    state_nxt = ORIG;
            end
        endcase
    end

    // Reset forces the passthrough view even if the register still says DUP.
    always_comb begin
        in_ready   = out_ready && !full;
        out_valid  = in_valid;
        out_instr  = in_instr;
        out_is_dup = 1'b0;
        if (reset) begin
            in_ready = out_ready;
        end else if (state == DUP) begin
            in_ready   = 1'b0;
            out_valid  = 1'b1;
            out_instr  = encode(mem[rd_ptr]);
            out_is_dup = 1'b1;
        end
    end
endmodule

// File: tb/tb_qed_dup_encoder.sv
// Bench for qed_dup_encoder: queue-based reference model, per-cycle compare,
// directed scenarios and randomized traffic.
module tb_qed_dup_encoder;
    localparam int DEPTH = 8;

    logic        clk;
    logic        reset, ena, drain, in_valid, out_ready;
    logic        in_ready, out_valid, out_is_dup, illegal;
    logic [31:0] in_instr, out_instr;
    logic [3:0]  fifo_count;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 0;

    logic [31:0] q[$];
    bit          m_dup = 0;
    bit          m_ill = 0;

    qed_dup_encoder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .ena(ena), .drain(drain),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_is_dup(out_is_dup), .fifo_count(fifo_count), .illegal(illegal)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // 0 unsupported, 1 R, 2 I, 3 LW, 4 SW
    function automatic int kind(input logic [31:0] x);
        int op, f3;
        op = int'(x & 32'h7f);
        f3 = int'((x >> 12) & 32'h7);
        if (op == 'h33) return 1;
        if (op == 'h13) return 2;
        if (op == 'h03 && f3 == 2) return 3;
        if (op == 'h23 && f3 == 2) return 4;
        return 0;
    endfunction

    function automatic int fld(input logic [31:0] x, input int lsb);
        return int'((x >> lsb) & 32'h1f);
    endfunction

    function automatic logic [31:0] setf(input logic [31:0] x, input int lsb);
        int f;
        f = fld(x, lsb);
        if (f != 0 && f < 16) f = f + 16;
        return (x & ~(32'h1f << lsb)) | (32'(f) << lsb);
    endfunction

    function automatic logic [31:0] model_enc(input logic [31:0] x);
        logic [31:0] y;
        int k;
        k = kind(x);
        y = x;
        if (k == 1 || k == 2 || k == 3) y = setf(y, 7);
        if (k != 0) y = setf(y, 15);
        if (k == 1 || k == 4) y = setf(y, 20);
`ifdef QED_MEM_OFFSET_EN
        if (k == 3 || k == 4) y = y | (32'h400 << 20);
`endif
        return y;
    endfunction

    function automatic bit model_hi(input logic [31:0] x);
        int k;
        k = kind(x);
        if ((k == 1 || k == 2 || k == 3) && fld(x, 7) >= 16) return 1;
        if (k != 0 && fld(x, 15) >= 16) return 1;
        if ((k == 1 || k == 4) && fld(x, 20) >= 16) return 1;
        return 0;
    endfunction

    // Model state advance on each rising edge.
    initial forever begin
        bit pushed;
        @(posedge clk);
        pushed = 0;
        if (reset) begin
            q.delete();
            m_dup = 0;
            m_ill = 0;
        end else if (!m_dup) begin
            if (ena && in_valid && out_ready && q.size() < DEPTH
                && kind(in_instr) != 0) begin
                q.push_back(in_instr);
                pushed = 1;
                if (model_hi(in_instr)) m_ill = 1;
            end
            if (pushed && q.size() == DEPTH) m_dup = 1;
            else if (!pushed && drain && q.size() > 0) m_dup = 1;
        end else if (out_ready) begin
            void'(q.pop_front());
            if (q.size() == 0) m_dup = 0;
        end
    end

    // Compare DUT outputs against the model every cycle.
    initial forever begin
        bit dupv;
        @(negedge clk);
        if (chk_en) begin
            dupv = m_dup && !reset;
            chk("fifo_count", 32'(fifo_count), 32'(q.size()));
            chk("illegal", 32'(illegal), 32'(m_ill));
            chk("out_is_dup", 32'(out_is_dup), 32'(dupv));
            if (dupv) begin
                chk("in_ready", 32'(in_ready), 0);
                chk("out_valid", 32'(out_valid), 1);
                chk("dup_instr", out_instr, model_enc(q[0]));
            end else begin
                chk("in_ready", 32'(in_ready),
                    32'(out_ready && (reset || q.size() < DEPTH)));
                chk("out_valid", 32'(out_valid), 32'(in_valid));
                if (in_valid) chk("pass_instr", out_instr, in_instr);
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rtype(input int rd, input int rs1,
                                          input int rs2);
        return (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h33;
    endfunction

    function automatic int rreg();
        if ($urandom_range(0, 15) == 0) return $urandom_range(16, 31);
        return $urandom_range(0, 15);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] x;
        x = $urandom;
        x = (x & ~(32'h1f << 7)) | (32'(rreg()) << 7);
        x = (x & ~(32'h1f << 15)) | (32'(rreg()) << 15);
        x = (x & ~(32'h1f << 20)) | (32'(rreg()) << 20);
        x = x & ~32'h707f;
        case ($urandom_range(0, 5))
            0: x = x | 32'h33;
            1: x = x | 32'h13;
            2: x = x | 32'h2003;
            3: x = x | 32'h2023;
            4: x = x | 32'h0003;
            default: x = x | 32'h37;
        endcase
        return x;
    endfunction

    // Issue one original, drain it, check the literal duplicate.
    task automatic one_dup(input string nm, input logic [31:0] orig,
                           input logic [31:0] dup);
        in_valid = 1; in_instr = orig; out_ready = 1; ena = 1; drain = 0;
        #1;
        chk({nm, "_pass"}, out_instr, orig);
        chk({nm, "_pass_dup"}, 32'(out_is_dup), 0);
        step;
        in_valid = 0; drain = 1;
        #1;
        chk({nm, "_cnt1"}, 32'(fifo_count), 1);
        chk({nm, "_still_orig"}, 32'(out_is_dup), 0);
        step;
        drain = 0;
        #1;
        chk({nm, "_dup_flag"}, 32'(out_is_dup), 1);
        chk({nm, "_dup_instr"}, out_instr, dup);
        step;
        #1;
        chk({nm, "_back_orig"}, 32'(out_is_dup), 0);
        chk({nm, "_cnt0"}, 32'(fifo_count), 0);
    endtask

    initial begin
        int guard;
        logic [31:0] lw_dup;
        reset = 1; ena = 0; drain = 0; in_valid = 1; out_ready = 1;
        in_instr = 32'h0000_0013;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1;
        #1;
        chk("rst_cnt", 32'(fifo_count), 0);
        chk("rst_dup", 32'(out_is_dup), 0);
        chk("rst_ill", 32'(illegal), 0);
        chk("rst_valid", 32'(out_valid), 1);
        chk("rst_ready", 32'(in_ready), 1);
        reset = 0;
        step;

        one_dup("add", 32'h002081B3, 32'h012889B3);
        one_dup("addi", 32'h00700293, 32'h00700A93);
`ifdef QED_MEM_OFFSET_EN
        lw_dup = 32'h40892A03;
`else
        lw_dup = 32'h00892A03;
`endif
        one_dup("lw", 32'h00812203, lw_dup);

        // Fill to DEPTH, then drain with a toggling consumer.
        out_ready = 1; ena = 1;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1;
            in_instr = rtype($urandom_range(1, 15), $urandom_range(0, 15), i);
            step;
        end
        in_valid = 0;
        #1;
        chk("full_cnt", 32'(fifo_count), DEPTH);
        chk("full_dup", 32'(out_is_dup), 1);
        chk("full_ready", 32'(in_ready), 0);
        guard = 0;
        while (out_is_dup && guard < 64) begin
            out_ready = $urandom_range(0, 1);
            step;
            guard++;
        end
        chk("drain_timeout", 32'(guard < 64), 1);
        chk("drained_cnt", 32'(fifo_count), 0);
        out_ready = 1;

        // Reset in the middle of the duplicate phase.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1;
            in_instr = rtype(i + 1, 2, 3);
            step;
        end
        in_valid = 0; drain = 1;
        step;
        drain = 0; out_ready = 0;
        #1;
        chk("mid_dup", 32'(out_is_dup), 1);
        chk("mid_cnt", 32'(fifo_count), 5);
        reset = 1; in_valid = 1;
        #1;
        chk("rst_in_dup_flag", 32'(out_is_dup), 0);
        chk("rst_in_dup_valid", 32'(out_valid), 1);
        step;
        reset = 0; in_valid = 0;
        #1;
        chk("post_rst_cnt", 32'(fifo_count), 0);
        chk("post_rst_dup", 32'(out_is_dup), 0);
        chk("post_rst_ill", 32'(illegal), 0);
        step; step;
        chk("no_more_dup", 32'(out_is_dup), 0);
        out_ready = 1; in_valid = 1; in_instr = 32'h002881B3;
        step;
        in_valid = 0;
        #1;
        chk("ill_set", 32'(illegal), 1);
        step; step;
        chk("ill_held", 32'(illegal), 1);

        reset = 1;
        step;
        reset = 0;

        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 99) == 0);
            ena       = ($urandom_range(0, 7) != 0);
            drain     = ($urandom_range(0, 9) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            step;
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
